keypad_scanner: RTL

Scans a 4x4 active-low matrix keypad and turns it into debounced key events. It is the input-side counterpart of the multiplexed seven-segment display driver, and uses the same column-strobed time-multiplexing scheme in the opposite direction. It drives one column low at a time, samples the rows, resolves each full scan frame to one key or none, and emits one `key_valid` pulse per debounced press. Downstream digit-entry logic consumes the key codes.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_scanner_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    typedef logic [3:0] key_code_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Number of low rows in one column sample, saturated at 2 ("more than one").
    function automatic logic [1:0] low_count(input logic [NUM_ROWS-1:0] low);
        logic [2:0] n;
        n = 3'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            n = n + {2'b00, low[r]};
        end
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] low);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (low[r]) idx = 2'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Plain two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column strobe, per-frame key resolution and
// press/release debounce producing one key_valid pulse per accepted press.
//
// state      | meaning
// IDLE       | no key accepted, waiting for a single-key frame
// PRESS_DB   | candidate key seen, counting consecutive matching frames
// PRESSED    | key accepted, key_held high
// RELEASE_DB | empty frames seen, counting toward release
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output key_code_t           key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] row_sync;
    logic [NUM_ROWS-1:0] row_low;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic             wrap;
    logic             frame_end;

    logic [1:0] acc_cnt_q;
    key_code_t  acc_code_q;
    logic [1:0] samp_cnt;
    key_code_t  samp_code;
    logic [2:0] acc_sum;
    logic [1:0] tot_cnt;
    key_code_t  frame_code;
    logic       frame_single;

    kp_state_t  state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [DB_W-1:0] db_inc;
    key_code_t  cand_q, cand_d;
    key_code_t  key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;

    // Idle rows read high, so the synchronizer resets to all ones.
    sync_2ff #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_in),
        .q_o   (row_sync)
    );

    assign row_low   = ~row_sync;
    assign wrap      = (div_q == DIV_LAST);
    assign frame_end = wrap && (col_idx_q == 2'd3);
    assign col_out   = ~(4'b0001 << col_idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
        end else if (wrap) begin
            div_q     <= '0;
            col_idx_q <= col_idx_q + 2'd1;
        end else begin
            div_q     <= div_q + DIV_ONE;
        end
    end

    // Frame result folds in the current (last) column sample combinationally.
    assign samp_cnt     = low_count(row_low);
    assign samp_code    = {first_low(row_low), col_idx_q};
    assign acc_sum      = {1'b0, acc_cnt_q} + {1'b0, samp_cnt};
    assign tot_cnt      = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
    assign frame_code   = (samp_cnt != 2'd0) ? samp_code : acc_code_q;
    assign frame_single = (tot_cnt == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
        end else if (wrap) begin
            if (col_idx_q == 2'd3) begin
                acc_cnt_q  <= 2'd0;
                acc_code_q <= '0;
            end else begin
                acc_cnt_q  <= tot_cnt;
                acc_code_q <= frame_code;
            end
        end
    end

    assign db_inc = db_cnt_q + DB_ONE;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_d  = frame_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = PRESSED;
                        end else begin
                            cand_d   = frame_code;
                            db_cnt_d = DB_ONE;
                            state_d  = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!frame_single) begin
                        state_d = IDLE;
                    end else if (frame_code != cand_q) begin
                        cand_d   = frame_code;
                        db_cnt_d = DB_ONE;
                    end else if (db_inc == DB_TARGET) begin
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = PRESSED;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                PRESSED: begin
                    if (!frame_single) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            key_held_d = 1'b0;
                            state_d    = IDLE;
                        end else begin
                            db_cnt_d = DB_ONE;
                            state_d  = RELEASE_DB;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (frame_single) begin
                        state_d = PRESSED;
                    end else if (db_inc == DB_TARGET) begin
                        key_held_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
